operand_unpacker: RTL and testbench

// - Input-side counterpart of the result packing stage: splits two packed IEEE-754 single operands into fields.
// - Fields per operand: sign, exponent, fraction with hidden bit, class flags.
// - Feeds the FPU pipeline front end.
// - 2-stage registered pipeline with valid/ready handshake, full throughput, sideband tag carried alongside.

---
 rtl/operand_unpacker_if.sv | 61 ++++++
 rtl/operand_unpacker.sv | 145 ++++++++++++++
 tb/tb_operand_unpacker.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_unpacker_if.sv
// operand_unpacker_if: operand-pair input stream and unpacked-field output stream.
// master drives operands and consumes fields; slave is the unpacker.
interface operand_unpacker_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_operand_a;
  logic [31:0]          in_operand_b;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic                 operand_sign_a;
  logic                 operand_sign_b;
  logic [7:0]           operand_exponent_a;
  logic [7:0]           operand_exponent_b;
  logic [23:0]          operand_fraction_a;
  logic [23:0]          operand_fraction_b;
  logic [4:0]           class_a;
  logic [4:0]           class_b;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid,
    output in_operand_a,
    output in_operand_b,
    output in_tag,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  operand_sign_a,
    input  operand_sign_b,
    input  operand_exponent_a,
    input  operand_exponent_b,
    input  operand_fraction_a,
    input  operand_fraction_b,
    input  class_a,
    input  class_b,
    input  out_tag
  );

  modport slave (
    input  in_valid,
    input  in_operand_a,
    input  in_operand_b,
    input  in_tag,
    output in_ready,
    output out_valid,
    input  out_ready,
    output operand_sign_a,
    output operand_sign_b,
    output operand_exponent_a,
    output operand_exponent_b,
    output operand_fraction_a,
    output operand_fraction_b,
    output class_a,
    output class_b,
    output out_tag
  );
endinterface

// File: rtl/operand_unpacker.sv
// operand_unpacker: 2-stage IEEE-754 single operand-pair field/class decoder.
// Build macro DENORMAL_FLUSH_EN: denormal inputs leave as signed zero.
module operand_unpacker #(
  parameter int TAG_WIDTH = 4
) (
  input logic               clk,
  input logic               reset_n,
  operand_unpacker_if.slave bus
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] frac;
    logic [4:0]  cls;
  } fields_t;

  localparam logic [4:0] CLS_SNAN = 5'b10000;
  localparam logic [4:0] CLS_QNAN = 5'b01000;
  localparam logic [4:0] CLS_INF  = 5'b00100;
  localparam logic [4:0] CLS_DEN  = 5'b00010;
  localparam logic [4:0] CLS_ZERO = 5'b00001;

  function automatic fields_t decode(
    input logic [31:0] x
  );
    fields_t     r;
    logic [22:0] f;
    logic        e_zero;
    logic        e_max;
    logic        f_zero;
    f      = x[22:0];
    e_zero = (x[30:23] == 8'h00);
    e_max  = (x[30:23] == 8'hFF);
    f_zero = (f == 23'd0);
    r.sign = x[31];
    r.exp  = x[30:23];
    r.frac = {!e_zero, f};
    r.cls  = 5'b00000;
    unique case (1'b1)
      e_zero && f_zero: r.cls = CLS_ZERO;
      e_zero && !f_zero: begin
`ifdef DENORMAL_FLUSH_EN
        r.cls  = CLS_ZERO;
        r.frac = 24'd0;
`else
        r.cls  = CLS_DEN;
`endif
      end
      e_max && f_zero: r.cls = CLS_INF;
      e_max && f[22]: r.cls = CLS_QNAN;
      e_max && !f[22] && !f_zero: r.cls = CLS_SNAN;
      default: r.cls = 5'b00000;
    endcase
    return r;
  endfunction

  logic                 s1_valid_q;
  logic                 s1_valid_d;
  logic [31:0]          s1_a_q;
  logic [31:0]          s1_a_d;
  logic [31:0]          s1_b_q;
  logic [31:0]          s1_b_d;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic [TAG_WIDTH-1:0] s1_tag_d;

  logic                 s2_valid_q;
  logic                 s2_valid_d;
  fields_t              s2_a_q;
  fields_t              s2_a_d;
  fields_t              s2_b_q;
  fields_t              s2_b_d;
  logic [TAG_WIDTH-1:0] s2_tag_q;
  logic [TAG_WIDTH-1:0] s2_tag_d;

  logic                 s1_accept;
  logic                 s2_accept;

  // Each stage refills whenever the stage after it is draining.
  always_comb begin
    s2_accept  = !s2_valid_q || bus.out_ready;
    s1_accept  = !s1_valid_q || s2_accept;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (s1_accept) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d   = bus.in_operand_a;
        s1_b_d   = bus.in_operand_b;
        s1_tag_d = bus.in_tag;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    s2_tag_d   = s2_tag_q;
    if (s2_accept) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_a_d   = decode(s1_a_q);
        s2_b_d   = decode(s1_b_q);
        s2_tag_d = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign bus.in_ready           = s1_accept;
  assign bus.out_valid          = s2_valid_q;
  assign bus.operand_sign_a     = s2_a_q.sign;
  assign bus.operand_sign_b     = s2_b_q.sign;
  assign bus.operand_exponent_a = s2_a_q.exp;
  assign bus.operand_exponent_b = s2_b_q.exp;
  assign bus.operand_fraction_a = s2_a_q.frac;
  assign bus.operand_fraction_b = s2_b_q.frac;
  assign bus.class_a            = s2_a_q.cls;
  assign bus.class_b            = s2_b_q.cls;
  assign bus.out_tag            = s2_tag_q;

endmodule

// File: tb/tb_operand_unpacker.sv
// tb_operand_unpacker: directed and random checks of operand_unpacker.
// Reference decode and queue-based pipeline occupancy model.
module tb_operand_unpacker;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  operand_unpacker_if #(.TAG_WIDTH(TW)) bus ();

  operand_unpacker #(.TAG_WIDTH(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [TW-1:0] tag;
    int            t;
  } pair_t;

  pair_t         q[$];
  logic [TW-1:0] emitted[$];
  int            nerr = 0;
  int            nchk = 0;
  int            cyc_n = 0;
  int            n_in = 0;
  int            n_out = 0;
  bit            stalled = 0;
  bit            blocked_seen = 0;
  logic [79:0]   snap = '0;

  function automatic logic [37:0] ref_dec(input logic [31:0] x);
    int unsigned e;
    int unsigned f;
    int unsigned frac;
    int unsigned cls;
    logic        s;
    s = x[31];
    e = (x >> 23) & 32'hFF;
    f = x & 32'h7FFFFF;
    frac = (e != 0) ? f + 32'h800000 : f;
    if (e == 0 && f == 0) cls = 1;
    else if (e == 0) begin
`ifdef DENORMAL_FLUSH_EN
      cls = 1;
      frac = 0;
`else
      cls = 2;
`endif
    end
    else if (e == 255 && f == 0) cls = 4;
    else if (e == 255 && f >= 32'h400000) cls = 8;
    else if (e == 255) cls = 16;
    else cls = 0;
    return {s, e[7:0], frac[23:0], cls[4:0]};
  endfunction

  function automatic logic [79:0] dut_all();
    return {bus.operand_sign_a, bus.operand_exponent_a,
            bus.operand_fraction_a, bus.class_a,
            bus.operand_sign_b, bus.operand_exponent_b,
            bus.operand_fraction_b, bus.class_b,
            bus.out_tag};
  endfunction

  task automatic chk(input string nm, input logic [79:0] obs,
                     input logic [79:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0b expected=%0b", nm, obs, exp);
    end
  endtask

  // One clock: drive, check against the model, update the model, advance.
  task automatic cyc(input bit v, input logic [31:0] a,
                     input logic [31:0] b, input logic [TW-1:0] tag,
                     input bit ordy);
    bit          fi;
    bit          fo;
    logic [79:0] cur;
    pair_t       e;
    bus.in_valid     = v;
    bus.in_operand_a = a;
    bus.in_operand_b = b;
    bus.in_tag       = tag;
    bus.out_ready    = ordy;
    #1;
    cur = dut_all();
    chk1("in_ready", bus.in_ready, (q.size() < 2) || ordy);
    chk1("out_valid", bus.out_valid,
         (q.size() > 0) && ((cyc_n - q[0].t) >= 2));
    if (stalled) chk("stable", cur, snap);
    fi = v && bus.in_ready;
    fo = bus.out_valid && ordy;
    if (v && !bus.in_ready) blocked_seen = 1;
    if (fo && q.size() > 0) begin
      e = q.pop_front();
      chk("data", cur, {ref_dec(e.a), ref_dec(e.b), e.tag});
      emitted.push_back(bus.out_tag);
      n_out++;
    end
    if (fi) begin
      q.push_back('{a, b, tag, cyc_n});
      n_in++;
    end
    stalled = bus.out_valid && !ordy;
    snap = cur;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 32'd0, 32'd0, '0, ordy);
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 3))
      0: e = 8'h00;
      1: e = 8'hFF;
      default: e = 8'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0: f = 23'd0;
      1: f = 23'd1;
      2: f = 23'h400000;
      default: f = 23'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  initial begin
    int sent;
    int base;
    int budget;
    int n_out0;
    bit ok;

    bus.in_valid     = 1'b0;
    bus.in_operand_a = '0;
    bus.in_operand_b = '0;
    bus.in_tag       = '0;
    bus.out_ready    = 1'b0;
    reset_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_data", dut_all(), 80'd0);

    // Normal operands, exact 2-cycle latency.
    cyc(1'b1, 32'h3F800000, 32'hC0490FDB, 4'd1, 1'b1);
    chk1("lat1", bus.out_valid, 1'b0);
    idle(1'b1);
    chk1("lat2", bus.out_valid, 1'b1);
    chk("norm_a", 80'({bus.operand_sign_a, bus.operand_exponent_a,
        bus.operand_fraction_a, bus.class_a}),
        80'({1'b0, 8'h7F, 24'h800000, 5'd0}));
    chk("norm_b", 80'({bus.operand_sign_b, bus.operand_exponent_b,
        bus.operand_fraction_b}), 80'({1'b1, 8'h80, 24'hC90FDB}));

    // Denormal and negative zero.
    cyc(1'b1, 32'h00000001, 32'h80000000, 4'd2, 1'b1);
    idle(1'b1);
`ifdef DENORMAL_FLUSH_EN
    chk("den_frac_a", 80'(bus.operand_fraction_a), 80'h0);
    chk("den_cls_a", 80'(bus.class_a), 80'h01);
`else
    chk("den_frac_a", 80'(bus.operand_fraction_a), 80'h1);
    chk("den_cls_a", 80'(bus.class_a), 80'h02);
`endif
    chk("zero_cls_b", 80'(bus.class_b), 80'h01);
    chk1("zero_sign_b", bus.operand_sign_b, 1'b1);

    // Infinity, quiet NaN, then signalling NaN.
    cyc(1'b1, 32'h7F800000, 32'h7FC00000, 4'd3, 1'b1);
    idle(1'b1);
    chk("inf_cls_a", 80'(bus.class_a), 80'h04);
    chk("qnan_cls_b", 80'(bus.class_b), 80'h08);
    cyc(1'b1, 32'h7F800001, 32'h00000000, 4'd4, 1'b1);
    idle(1'b1);
    chk("snan_cls_a", 80'(bus.class_a), 80'h10);
    chk("snan_f_a", 80'(bus.operand_fraction_a[22:0]), 80'h1);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back tags 1..6 with a downstream stall on cycles 3-6.
    emitted.delete();
    blocked_seen = 0;
    n_out0 = n_out;
    sent = 0;
    for (int c = 1; c <= 20; c++) begin
      base = n_in;
      cyc(sent < 6, $urandom, $urandom, TW'(sent + 1), !(c >= 3 && c <= 6));
      if (n_in != base) sent++;
    end
    chk1("stall_blocked", blocked_seen, 1'b1);
    chk("stall_count", 80'(n_out - n_out0), 80'd6);
    ok = (emitted.size() == 6);
    for (int i = 0; i < emitted.size() && i < 6; i++)
      if (emitted[i] != TW'(i + 1)) ok = 0;
    chk1("stall_order", ok, 1'b1);

    // Random traffic against the reference decode.
    base = n_in;
    budget = 0;
    while ((n_in - base) < 10000 && budget < 40000) begin
      cyc($urandom_range(0, 9) < 7, rand_op(), rand_op(), TW'($urandom),
          $urandom_range(0, 9) < 7);
      budget++;
    end
    chk1("rand_budget", (n_in - base) >= 10000, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("rand_drain", 80'(q.size()), 80'd0);
    chk("beats_match", 80'(n_out), 80'(n_in));

    // Reset with two pairs in flight.
    cyc(1'b1, 32'h40000000, 32'h40400000, 4'd9, 1'b0);
    cyc(1'b1, 32'h40800000, 32'h40A00000, 4'd10, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc_n++;
    q.delete();
    stalled = 0;
    chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_data", dut_all(), 80'd0);
    base = n_out;
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("no_stale", 80'(n_out - base), 80'd0);
    cyc(1'b1, 32'h7F800000, 32'h00000003, 4'd5, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("post_rst_beat", 80'(n_out - base), 80'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
